// File: rtl/pe_types.sv
// Shared PE types: direction ports, port masks and link credit defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_types;

    localparam int PE_NUM_PORTS    = 4;
    localparam int PE_LINK_CREDITS = 4;

    typedef logic [PE_NUM_PORTS-1:0] port_mask_t;

    // Direction port index; its value is the bit position in a port_mask_t.
    typedef enum logic [1:0] {
        DIR_NORTH = 2'd0,
        DIR_EAST  = 2'd1,
        DIR_SOUTH = 2'd2,
        DIR_WEST  = 2'd3
    } port_dir_t;

    function automatic port_mask_t dir_bit(input port_dir_t d);
        return port_mask_t'(1) << d;
    endfunction

endpackage

// File: rtl/pe_egress_credit_ctr.sv
// Single-port saturating credit counter mirroring free space in a neighbour FIFO.
// Latency: a return in cycle N is visible on has_credit in cycle N+1.
// Backpressure: has_credit low blocks the port; returns at full credit set sticky ovf.
//
// Ports: clk, rst_n; fire (push this cycle, only honoured while has_credit);
//        ret (neighbour freed one entry); has_credit (count != 0); ovf (sticky).
module pe_egress_credit_ctr
    import pe_types::*;
#(
    parameter int CREDITS = PE_LINK_CREDITS,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fire,
    input  logic ret,
    output logic has_credit,
    output logic ovf
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    logic [CNT_W-1:0] count;
    logic             take;

    assign has_credit = (count != '0);
    // Guard so a stray fire at zero can never wrap the counter.
    assign take       = fire && has_credit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= FULL;
            ovf   <= 1'b0;
        end else begin
            // Fire and return in the same cycle cancel out.
            if (take && !ret) begin
                count <= count - 1'b1;
            end else if (!take && ret) begin
                if (count == FULL) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pe_egress_dispatch.sv
// PE egress dispatch: holds one packet and pushes it to each credited destination port.
// Latency: packet accepted at edge N drives out_valid in cycle N+1 for credited ports.
// Backpressure: in_ready drops while any destination is still pending without credit.
//
// Ports: clk, rst_n; in_valid/in_ready/in_data/in_dest_mask (packet in);
//        out_valid[PORTS]/out_data (per-port push, shared payload);
//        credit_ret[PORTS] (neighbour dequeue pulses); drop (zero-mask discard pulse);
//        err_credit_ovf (sticky credit overflow).
module pe_egress_dispatch
    import pe_types::*;
#(
    parameter int PORTS   = PE_NUM_PORTS,
    parameter int DATA_W  = 32,
    parameter int CREDITS = PE_LINK_CREDITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PORTS-1:0]  in_dest_mask,
    output logic [PORTS-1:0]  out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [PORTS-1:0]  credit_ret,
    output logic              drop,
    output logic              err_credit_ovf
);

    logic [DATA_W-1:0] hold_data;
    logic [PORTS-1:0]  pending;
    logic [PORTS-1:0]  has_credit;
    logic [PORTS-1:0]  ovf;
    logic [PORTS-1:0]  fire;
    logic              accept;

    // Everything here is a function of registers only, so outputs never
    // combinationally follow same-cycle inputs.
    assign fire      = pending & has_credit;
    assign out_valid = fire;
    assign out_data  = hold_data;
    // Ready when the held packet completes delivery this cycle (or nothing held),
    // which gives one packet per cycle when credits allow.
    assign in_ready  = ((pending & ~fire) == '0);
    assign accept    = in_valid && in_ready;

    assign err_credit_ovf = |ovf;

    for (genvar p = 0; p < PORTS; p++) begin : g_ctr
        pe_egress_credit_ctr #(
            .CREDITS (CREDITS)
        ) u_ctr (
            .clk        (clk),
            .rst_n      (rst_n),
            .fire       (fire[p]),
            .ret        (credit_ret[p]),
            .has_credit (has_credit[p]),
            .ovf        (ovf[p])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            pending   <= '0;
            drop      <= 1'b0;
        end else begin
            drop <= accept && (in_dest_mask == '0);
            if (accept) begin
                // A new packet replaces whatever bits fired this cycle; by
                // construction all remaining bits did fire.
                hold_data <= in_data;
                pending   <= in_dest_mask;
            end else begin
                pending <= pending & ~fire;
            end
        end
    end

endmodule

// File: tb/tb_pe_egress_dispatch.sv
module tb_pe_egress_dispatch;

    localparam int PORTS  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [PORTS-1:0]  in_dest_mask;
    logic [PORTS-1:0]  out_valid;
    logic [DATA_W-1:0] out_data;
    logic [PORTS-1:0]  credit_ret;
    logic              drop;
    logic              err_credit_ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q [PORTS][$];

    pe_egress_dispatch #(
        .PORTS   (PORTS),
        .DATA_W  (DATA_W),
        .CREDITS (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_dest_mask   (in_dest_mask),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .credit_ret     (credit_ret),
        .drop           (drop),
        .err_credit_ovf (err_credit_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks right after are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_credit(input int p, input int exp);
        logic [63:0] v;
        case (p)
            0: v = 64'(dut.g_ctr[0].u_ctr.count);
            1: v = 64'(dut.g_ctr[1].u_ctr.count);
            2: v = 64'(dut.g_ctr[2].u_ctr.count);
            default: v = 64'(dut.g_ctr[3].u_ctr.count);
        endcase
        check($sformatf("credit[%0d]", p), v, 64'(exp));
    endtask

    // Drive one packet for the next edge; expect_mask lists the ports that will emit it.
    task automatic offer(input logic [PORTS-1:0] mask, input logic [DATA_W-1:0] data,
                         input logic [PORTS-1:0] expect_mask);
        in_valid     = 1'b1;
        in_data      = data;
        in_dest_mask = mask;
        for (int p = 0; p < PORTS; p++)
            if (expect_mask[p]) exp_q[p].push_back(data);
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        in_data      = '0;
        in_dest_mask = '0;
    endtask

    // Scoreboard monitor: every emitted beat must match the next expected payload.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < PORTS; p++) begin
                if (out_valid[p]) begin
                    if (exp_q[p].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_emit port %0d: got data %0h, expected no emission",
                                 p, out_data);
                    end else begin
                        check($sformatf("emit_data[%0d]", p), 64'(out_data),
                              64'(exp_q[p].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        credit_ret = '0;
        idle_in();
        #12;
        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_drop", 64'(drop), 64'h0);
        check("rst_err", 64'(err_credit_ovf), 64'h0);
        for (int p = 0; p < PORTS; p++) check_credit(p, 4);
        #1 rst_n = 1'b1;
        tick();

        // 1: unicast to port 0
        offer(4'b0001, 32'hA5, 4'b0001);
        check("t1_ready_pre", 64'(in_ready), 64'h1);
        tick();
        idle_in();
        check("t1_out_valid", 64'(out_valid), 64'h1);
        check("t1_out_data", 64'(out_data), 64'hA5);
        check("t1_ready", 64'(in_ready), 64'h1);
        tick();
        check("t1_out_valid_after", 64'(out_valid), 64'h0);
        check_credit(0, 3);
        credit_ret = 4'b0001;
        tick();
        credit_ret = '0;
        check_credit(0, 4);

        // 2: five back-to-back packets to port 1, no returns
        for (int i = 0; i < 5; i++) begin
            offer(4'b0010, 32'h100 + i, 4'b0010);
            tick();
            if (i < 4) begin
                check($sformatf("t2_valid_%0d", i), 64'(out_valid), 64'h2);
                check($sformatf("t2_data_%0d", i), 64'(out_data), 64'(32'h100 + i));
            end
        end
        idle_in();
        check("t2_stall_valid", 64'(out_valid), 64'h0);
        check("t2_stall_ready", 64'(in_ready), 64'h0);
        check_credit(1, 0);
        tick();
        check("t2_stall_valid2", 64'(out_valid), 64'h0);
        credit_ret = 4'b0010;
        tick();
        credit_ret = '0;
        check("t2_fifth_valid", 64'(out_valid), 64'h2);
        check("t2_fifth_data", 64'(out_data), 64'h104);
        check("t2_fifth_ready", 64'(in_ready), 64'h1);
        tick();
        check("t2_done_valid", 64'(out_valid), 64'h0);
        check_credit(1, 0);
        credit_ret = 4'b0010;
        repeat (4) tick();
        credit_ret = '0;
        check_credit(1, 4);

        // 3: drain port 3, then multicast 1011 with partial delivery
        for (int i = 0; i < 4; i++) begin
            offer(4'b1000, 32'h300 + i, 4'b1000);
            tick();
        end
        idle_in();
        tick();
        check_credit(3, 0);
        offer(4'b1011, 32'hCAFE, 4'b1011);
        tick();
        offer(4'b0001, 32'hDEAD, 4'b0000);
        check("t3_partial_valid", 64'(out_valid), 64'h3);
        check("t3_partial_ready", 64'(in_ready), 64'h0);
        tick();
        check("t3_wait_valid", 64'(out_valid), 64'h0);
        check("t3_wait_ready", 64'(in_ready), 64'h0);
        check("t3_hold_data", 64'(out_data), 64'hCAFE);
        credit_ret = 4'b1000;
        tick();
        credit_ret = '0;
        check("t3_port3_valid", 64'(out_valid), 64'h8);
        check("t3_port3_data", 64'(out_data), 64'hCAFE);
        check("t3_port3_ready", 64'(in_ready), 64'h1);
        exp_q[0].push_back(32'hDEAD);
        tick();
        idle_in();
        check("t3_next_valid", 64'(out_valid), 64'h1);
        check("t3_next_data", 64'(out_data), 64'hDEAD);
        tick();
        check("t3_idle_valid", 64'(out_valid), 64'h0);
        // credits now: port0 2, port1 3, port3 0
        credit_ret = 4'b1011; tick();
        credit_ret = 4'b1001; tick();
        credit_ret = 4'b1000; tick(); tick();
        credit_ret = '0;
        check_credit(0, 4);
        check_credit(1, 4);
        check_credit(3, 4);

        // 4: streaming on port 2 with a return every fire cycle
        for (int i = 0; i < 10; i++) begin
            offer(4'b0100, 32'h200 + i, 4'b0100);
            credit_ret = (i > 0) ? 4'b0100 : 4'b0000;
            tick();
            check_credit(2, 4);
        end
        idle_in();
        credit_ret = 4'b0100;
        tick();
        credit_ret = '0;
        check_credit(2, 4);
        check("t4_err", 64'(err_credit_ovf), 64'h0);

        // 5: return at full credit on port 0
        credit_ret = 4'b0001;
        tick();
        credit_ret = '0;
        check("t5_err", 64'(err_credit_ovf), 64'h1);
        check_credit(0, 4);
        tick(); tick();
        check("t5_err_sticky", 64'(err_credit_ovf), 64'h1);

        // 6: zero-mask packet is dropped
        offer(4'b0000, 32'h77, 4'b0000);
        tick();
        idle_in();
        check("t6_drop", 64'(drop), 64'h1);
        check("t6_valid", 64'(out_valid), 64'h0);
        check("t6_ready", 64'(in_ready), 64'h1);
        tick();
        check("t6_drop_clear", 64'(drop), 64'h0);
        check("t6_valid2", 64'(out_valid), 64'h0);

        // 7: reset asserted mid-multicast
        for (int i = 0; i < 4; i++) begin
            offer(4'b0100, 32'h400 + i, 4'b0100);
            tick();
        end
        idle_in();
        tick();
        check_credit(2, 0);
        offer(4'b0101, 32'hBEEF, 4'b0001);
        tick();
        idle_in();
        check("t7_partial_valid", 64'(out_valid), 64'h1);
        tick();
        check("t7_stuck_ready", 64'(in_ready), 64'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 64'(out_valid), 64'h0);
        check("t7_rst_pending", 64'(dut.pending), 64'h0);
        check("t7_rst_ready", 64'(in_ready), 64'h1);
        check("t7_rst_err", 64'(err_credit_ovf), 64'h0);
        check_credit(2, 4);
        check_credit(0, 4);
        #3 rst_n = 1'b1;
        offer(4'b0001, 32'h55, 4'b0001);
        tick();
        idle_in();
        check("t7_first_accept", 64'(out_valid), 64'h1);
        check("t7_first_data", 64'(out_data), 64'h55);
        tick();
        tick();

        for (int p = 0; p < PORTS; p++)
            check($sformatf("leftover_q[%0d]", p), 64'(exp_q[p].size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
